// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions and fetch FSM encoding.
// The HALT state is present only when FETCH_HALT_DETECT_EN is defined.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;
`endif

    function automatic logic is_halt_op(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_next_pc.sv
// Combinational next-PC select: jump beats taken branch beats sequential.
// All additions wrap modulo 2^ADDR_W.
module instr_next_pc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       instr,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] branch_target;
    logic [5:0]        opcode_unused;

    // Opcode bits are decoded elsewhere; they play no part in the target math.
    assign opcode_unused = instr[OPC_MSB:OPC_LSB];

    assign jump_target   = {pc_plus4[ADDR_W-1:28], instr[TGT_MSB:TGT_LSB], 2'b00};
    assign branch_offset = {{(ADDR_W-18){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem read at a time, holds the word for decode.
// Build option FETCH_HALT_DETECT_EN stops fetch permanently on opcode 6'b111111.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one cycle after reset release
// ST_FETCH | imem_req high at pc, waiting for imem_rvalid
// ST_HOLD  | instr valid for decode, waiting for id_ready
// ST_HALT  | halt opcode handed off, fetch stopped until reset (option)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              id_ready,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              halted
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic              capture;
    logic              handoff;
    logic              pc_update;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign imem_addr = pc;

    instr_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        capture    = 1'b0;
        handoff    = 1'b0;
        pc_update  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (id_ready) begin
                    handoff    = 1'b1;
                    pc_update  = 1'b1;
                    state_next = ST_FETCH;
`ifdef FETCH_HALT_DETECT_EN
                    if (is_halt_op(instr)) begin
                        pc_update  = 1'b0;
                        state_next = ST_HALT;
                    end
`endif
                end
            end
`ifdef FETCH_HALT_DETECT_EN
            ST_HALT: begin
                state_next = ST_HALT;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end else if (handoff) begin
                instr_valid <= 1'b0;
            end
            if (pc_update) begin
                pc <= next_pc;
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    assign halted = (state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver queues expected fetch addresses
// and handoffs, a negedge monitor pops and compares them as the DUT presents them.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        id_ready = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;

    int passed = 0;
    int total = 0;

    logic [31:0] addr_q[$];
    logic [63:0] hand_q[$];
    logic        req_prev = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: new fetch requests and handoffs are compared against the queues.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [63:0] eh;
        if (rst_n) begin
            if (instr_valid && id_ready) begin
                if (hand_q.size() == 0) check("sb_unexpected_handoff", pc, 32'hxxxx_xxxx);
                else begin
                    eh = hand_q.pop_front();
                    check("sb_handoff_pc", pc, eh[63:32]);
                    check("sb_handoff_instr", instr, eh[31:0]);
                end
            end
            if (imem_req && !req_prev) begin
                if (addr_q.size() == 0) check("sb_unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
                else begin
                    ea = addr_q.pop_front();
                    check("sb_fetch_addr", imem_addr, ea);
                end
            end
        end
        req_prev = imem_req;
    end

    task automatic run_instr(input logic [31:0] word, input int delay, input int hold,
                             input logic br, input logic jp, input logic zr,
                             input logic [31:0] exp_next, input bit push_next);
        logic [31:0] a;
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            check("req_timeout", {31'b0, imem_req}, 32'd1);
            return;
        end
        a = imem_addr;
        for (int i = 0; i < delay; i++) begin
            id_ready = 1'b1;
            check("fetch_req_held", {31'b0, imem_req}, 32'd1);
            check("fetch_addr_stable", imem_addr, a);
            check("fetch_no_valid", {31'b0, instr_valid}, 32'd0);
            @(posedge clk); #1;
        end
        id_ready    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_instr", instr, word);
        check("hold_pc_plus4", pc_plus4, a + 32'd4);
        for (int i = 0; i < hold; i++) begin
            branch = 1'b1;
            jump   = 1'b1;
            zero   = 1'b1;
            imem_rvalid = (i == 1);
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            check("hold_instr_stable", instr, word);
            check("hold_pc_stable", pc, a);
            check("hold_no_req", {31'b0, imem_req}, 32'd0);
            check("hold_valid_stable", {31'b0, instr_valid}, 32'd1);
        end
        branch   = br;
        jump     = jp;
        zero     = zr;
        id_ready = 1'b1;
        hand_q.push_back({a, word});
        if (push_next) addr_q.push_back(exp_next);
        @(posedge clk); #1;
        id_ready = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        zero     = 1'b0;
        check("after_valid_clear", {31'b0, instr_valid}, 32'd0);
        if (push_next) begin
            check("after_refetch_req", {31'b0, imem_req}, 32'd1);
            check("after_halted_low", {31'b0, halted}, 32'd0);
        end else begin
            check("after_halt_pc", pc, a);
        end
    endtask

    initial begin
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        addr_q.push_back(32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("idle_no_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk); #1;
        check("first_req_after_idle", {31'b0, imem_req}, 32'd1);

        run_instr(32'h2001_0005, 0, 0, 0, 0, 0, 32'h0000_0004, 1);
        run_instr(32'h8C02_0000, 3, 5, 0, 0, 0, 32'h0000_0008, 1);
        run_instr(32'h0000_0020, 0, 1, 1, 0, 0, 32'h0000_000C, 1);
        run_instr(32'h0800_0004, 1, 0, 1, 1, 1, 32'h0000_0010, 1);
        run_instr(32'h1000_FFFC, 0, 0, 1, 0, 1, 32'h0000_0004, 1);
        run_instr(32'h0800_0004, 0, 0, 0, 1, 0, 32'h0000_0010, 1);
        run_instr(32'h1000_FFFC, 0, 0, 1, 0, 0, 32'h0000_0014, 1);
        run_instr(32'h0810_0008, 0, 0, 0, 1, 0, 32'h0040_0020, 1);
        run_instr(32'h0810_0010, 0, 0, 0, 1, 0, 32'h0040_0040, 1);
        run_instr(32'h0800_0004, 0, 0, 0, 1, 0, 32'h0000_0010, 1);
        run_instr(32'h1000_FFFA, 0, 0, 1, 0, 1, 32'hFFFF_FFFC, 1);
        run_instr(32'h2001_0005, 0, 0, 0, 0, 0, 32'h0000_0000, 1);
`ifdef FETCH_HALT_DETECT_EN
        run_instr(32'hFC00_0000, 0, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 12; i++) begin
            check("halt_halted", {31'b0, halted}, 32'd1);
            check("halt_no_req", {31'b0, imem_req}, 32'd0);
            check("halt_no_valid", {31'b0, instr_valid}, 32'd0);
            @(posedge clk); #1;
        end
`else
        run_instr(32'hFC00_0000, 0, 0, 0, 0, 0, 32'h0000_0004, 1);
`endif
        // Asynchronous reset away from any clock edge, mid-fetch in the default build.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_pc", pc, 32'h0);
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_halted", {31'b0, halted}, 32'd0);
        addr_q.push_back(32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(32'h2001_0005, 1, 0, 0, 0, 0, 32'h0000_0004, 1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_addr_q_drained", addr_q.size(), 32'd0);
        check("sb_hand_q_drained", hand_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
